// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// Module  : pipe_ctrl_if
// Brief   : Stall-request / multi-cycle / flush bundle between pipeline and pipe_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_ctrl_if #(
    parameter int LEN_W = 6
);
    logic             stallreq_if;
    logic             stallreq_id;
    logic             stallreq_mem;
    logic             mc_start;
    logic [LEN_W-1:0] mc_len;
    logic             flush_req;
    logic [5:0]       stall;
    logic             flush;
    logic             mc_done;
    logic             mc_busy;
    logic [31:0]      stall_cnt;

    // master: pipeline stages raising requests; slave: the controller
    modport master (
        output stallreq_if, stallreq_id, stallreq_mem, mc_start, mc_len, flush_req,
        input  stall, flush, mc_done, mc_busy, stall_cnt
    );
    modport slave (
        input  stallreq_if, stallreq_id, stallreq_mem, mc_start, mc_len, flush_req,
        output stall, flush, mc_done, mc_busy, stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module  : pipe_ctrl
// Brief   : Pipeline hazard controller: prioritised stall vector, flush,
//           multi-cycle op sequencing. Optional stall counter: PIPE_STALL_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
    parameter int LEN_W = 6
) (
    input  wire          clk,
    input  wire          rst,
    pipe_ctrl_if.slave   bus
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    localparam logic [5:0]       c_STALL_MEM = 6'b011111;
    localparam logic [5:0]       c_STALL_EX  = 6'b001111;
    localparam logic [5:0]       c_STALL_ID  = 6'b000111;
    localparam logic [5:0]       c_STALL_IF  = 6'b000011;
    localparam logic [LEN_W-1:0] c_ZERO      = '0;
    localparam logic [LEN_W-1:0] c_ONE       = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] w_len_eff;
    logic             w_ex_act;
    logic             w_flush;
    logic             w_mc_done;
    logic [5:0]       w_stall;

    assign w_len_eff = (bus.mc_len == c_ZERO) ? c_ONE : bus.mc_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= c_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_ex_act  = 1'b0;
        w_flush   = 1'b0;
        w_mc_done = 1'b0;
        w_stall   = 6'b000000;

        if (rst) begin
            state_d = RUN;
            cnt_d   = c_ZERO;
        end else if (bus.flush_req) begin
            // flush outranks everything, including a start in the same cycle
            w_flush = 1'b1;
            state_d = RUN;
            cnt_d   = c_ZERO;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.mc_start) begin
                        w_ex_act = 1'b1;
                        state_d  = MC_BUSY;
                        cnt_d    = w_len_eff;
                    end
                end
                MC_BUSY: begin
                    if (cnt_q > c_ONE) begin
                        w_ex_act = 1'b1;
                        if (!bus.stallreq_mem) begin
                            cnt_d = cnt_q - c_ONE;
                        end
                    end else if (!bus.stallreq_mem) begin
                        // last cycle: result valid unless memory is frozen
                        w_mc_done = 1'b1;
                        state_d   = RUN;
                        cnt_d     = c_ZERO;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = c_ZERO;
                end
            endcase

            if (bus.stallreq_mem) begin
                w_stall = c_STALL_MEM;
            end else if (w_ex_act) begin
                w_stall = c_STALL_EX;
            end else if (bus.stallreq_id) begin
                w_stall = c_STALL_ID;
            end else if (bus.stallreq_if) begin
                w_stall = c_STALL_IF;
            end
        end
    end

    assign bus.stall   = w_stall;
    assign bus.flush   = w_flush;
    assign bus.mc_done = w_mc_done;
    assign bus.mc_busy = (state_q == MC_BUSY);

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((w_stall != 6'b000000) && !w_flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'h0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = 32'h0;
`endif

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter LEN_W, default 6, width of the multi-cycle length field and down-counter.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port stallreq_if  input  1  fetch-stage stall request (instruction not ready).
REQ-005 The block SHALL have port stallreq_id  input  1  decode-stage stall request (load-use hazard).
REQ-006 The block SHALL have port stallreq_mem  input  1  memory-stage stall request (data access pending).
REQ-007 The block SHALL have port mc_start  input  1  one-cycle pulse from execute: multi-cycle op (mul/div) begins.
REQ-008 The block SHALL have port mc_len  input  LEN_W  op length N in cycles, sampled with mc_start.
REQ-009 The block SHALL have port flush_req  input  1  pipeline flush request (exception/redirect).
REQ-010 The block SHALL have port stall  output  6  per-stage freeze: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
REQ-011 The block SHALL have port flush  output  1  clear all pipeline registers this cycle.
REQ-012 The block SHALL have port mc_done  output  1  one-cycle pulse: multi-cycle result valid at EX.
REQ-013 The block SHALL have port mc_busy  output  1  high while state is MC_BUSY.
REQ-014 The block SHALL have port stall_cnt  output  32  stall-cycle counter (present only with PIPE_STALL_CNT_EN).

Function
REQ-015 The stall vector SHALL be combinational from the highest active source: mem 6'b011111 > ex 6'b001111 > id 6'b000111 > if 6'b000011 > none 6'b000000.
REQ-016 The ex source SHALL be active when (state RUN and mc_start accepted) or (state MC_BUSY and cnt > 1).
REQ-017 The FSM SHALL have states RUN and MC_BUSY; reset state RUN.
REQ-018 In RUN, accepted mc_start SHALL load cnt = N (mc_len = 0 treated as N = 1) and move to MC_BUSY at the next edge.
REQ-019 In MC_BUSY with cnt > 1, cnt SHALL decrement by one per cycle in which stallreq_mem is low; with stallreq_mem high, cnt SHALL hold.
REQ-020 In MC_BUSY with cnt == 1 and stallreq_mem low, mc_done SHALL be 1 for that cycle and state SHALL return to RUN; mc_start of N from cycle T thus gives ex stall in cycles T..T+N-1 and mc_done in T+N, absent mem stalls.
REQ-021 With cnt == 1 and stallreq_mem high, mc_done SHALL be withheld and cnt held until stallreq_mem drops.
REQ-022 mc_start while MC_BUSY SHALL be ignored (no reload, no error).
REQ-023 flush_req SHALL have top priority: flush = flush_req combinationally, stall = 6'b000000 that cycle, mc_done = 0.
REQ-024 flush_req in MC_BUSY SHALL abort the op: state RUN, cnt 0 at the next edge, no mc_done ever issued for it.
REQ-025 flush_req and mc_start in the same cycle SHALL drop the start (state stays RUN).
REQ-026 mc_busy SHALL be registered state (high exactly in MC_BUSY cycles).

Reset
REQ-027 While rst is high at a clock edge, state SHALL become RUN, cnt 0, stall_cnt 0.
REQ-028 During a cycle with rst high, stall, flush and mc_done SHALL be driven 0 regardless of inputs; reset mid-op SHALL discard the op without mc_done.

Configuration
REQ-029 With macro PIPE_STALL_CNT_EN defined, stall_cnt SHALL increment by one each non-reset cycle where stall != 0 and flush == 0, saturating at 32'hFFFFFFFF.
REQ-030 Without PIPE_STALL_CNT_EN, the port stall_cnt SHALL be tied to 32'h0 and no counter logic SHALL exist; all other behaviour identical.

Verification
REQ-031 Load-use: stallreq_id=1 for 1 cycle -> stall=6'b000111 that cycle, 0 after; stall_cnt +1 (macro on).
REQ-032 Divide: mc_start with mc_len=5 at T -> stall=6'b001111 T..T+4, mc_done=1 only at T+5, mc_busy T+1..T+5.
REQ-033 Mem over div: mc_len=3 at T, stallreq_mem=1 at T+1..T+2 -> stall=6'b011111 at T+1..T+2, mc_done at T+5.
REQ-034 Abort: mc_len=8 at T, flush_req at T+3 -> flush=1, stall=0 at T+3; mc_busy=0 from T+4; mc_done never asserts.
REQ-035 Edge lengths: mc_len=0 and mc_len=1 -> stall only at T, mc_done at T+1; mc_start during MC_BUSY -> cnt unchanged.
REQ-036 Reset mid-op: mc_len=10 at T, rst at T+2 -> outputs 0 during T+2, RUN/cnt 0 after, no mc_done; stall_cnt 0.
